// File: rtl/multipack_assembler.sv
// Byte-stream to packed-record assembler: packs 8-bit elements MSB-first into a
// (3+NUM_D)x64-bit record and presents it on a registered valid/ready output.
module multipack_assembler #(
  parameter  int NUM_D = 3,
  localparam int BYTES = 8 * (3 + NUM_D),
  localparam int W     = 8 * BYTES,
  localparam int LW    = $clog2(BYTES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [LW-1:0] out_len
);

  localparam int SHW = $clog2(W) + 1;

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  asm_q, asm_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic [LW-1:0] out_len_q, out_len_d;

  logic          accept_s;
  logic          drain_s;
  logic          slot_free_s;
  logic          complete_s;
  logic [LW-1:0] len_s;
  logic [SHW-1:0] shamt_s;
  logic [W-1:0]  asm_wr_s;

  // Outputs are forced to their reset values while rst is high so nothing transfers.
  assign in_ready  = (state_q == ST_FILL) && !rst;
  assign out_valid = out_valid_q && !rst;
  assign out_data  = rst ? {W{1'b0}} : out_data_q;
  assign out_len   = rst ? {LW{1'b0}} : out_len_q;

  assign accept_s    = in_valid && in_ready;
  assign drain_s     = out_valid_q && out_ready;
  assign slot_free_s = !out_valid_q || out_ready;
  assign complete_s  = accept_s && ((cnt_q == LW'(BYTES - 1)) || in_last);
  assign len_s       = cnt_q + {{(LW-1){1'b0}}, 1'b1};

  // Unwritten bytes of asm are always zero, so OR-ing the shifted byte in is a write.
  assign shamt_s  = SHW'(W - 8) - SHW'({cnt_q, 3'b000});
  assign asm_wr_s = asm_q | ({{(W-8){1'b0}}, in_data} << shamt_s);

  // Next-state, assembly buffer and output slot update.
  always_comb begin
    state_d     = state_q;
    asm_d       = asm_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;
    out_len_d   = out_len_q;
    case (state_q)
      ST_FILL: begin
        if (accept_s) begin
          if (complete_s) begin
            if (slot_free_s) begin
              out_data_d  = asm_wr_s;
              out_len_d   = len_s;
              out_valid_d = 1'b1;
              asm_d       = {W{1'b0}};
              cnt_d       = {LW{1'b0}};
            end else begin
              // cnt doubles as the latched length while the record waits in HOLD.
              asm_d   = asm_wr_s;
              cnt_d   = len_s;
              state_d = ST_HOLD;
            end
          end else begin
            asm_d = asm_wr_s;
            cnt_d = len_s;
          end
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_HOLD: begin
        if (drain_s) begin
          out_data_d  = asm_q;
          out_len_d   = cnt_q;
          out_valid_d = 1'b1;
          asm_d       = {W{1'b0}};
          cnt_d       = {LW{1'b0}};
          state_d     = ST_FILL;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FILL;
      asm_q       <= {W{1'b0}};
      cnt_q       <= {LW{1'b0}};
      out_valid_q <= 1'b0;
      out_data_q  <= {W{1'b0}};
      out_len_q   <= {LW{1'b0}};
    end else begin
      state_q     <= state_d;
      asm_q       <= asm_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_len_q   <= out_len_d;
    end
  end

endmodule

// File: tb/tb_multipack_assembler.sv
// Self-checking bench for multipack_assembler: directed scenarios plus randomized
// traffic, scored against a byte-queue model of record assembly.
module tb_multipack_assembler;

  localparam int NUM_D = 3;
  localparam int BYTES = 8 * (3 + NUM_D);
  localparam int W     = 8 * BYTES;
  localparam int LW    = $clog2(BYTES + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    in_data = 8'h00;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [LW-1:0] out_len;

  logic rdy_man  = 1'b0;
  logic rdy_auto = 1'b0;
  int   rdy_mode = 0;   // 0 manual, 1 toggle each cycle, 2 random

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0]   m_bytes[$];
  logic [W-1:0] exp_data_q[$];
  int           exp_len_q[$];
  logic [W-1:0] got_data_q[$];
  int           got_len_q[$];

  assign out_ready = (rdy_mode != 0) ? rdy_auto : rdy_man;

  multipack_assembler #(.NUM_D(NUM_D)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_len(out_len)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rdy_mode != 0) begin
      #1;
      rdy_auto <= (rdy_mode == 1) ? ~rdy_auto : 1'($urandom_range(0, 1));
    end
  end

  function automatic logic [W-1:0] build_rec();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < m_bytes.size(); i++) r[W-1-8*i -: 8] = m_bytes[i];
    return r;
  endfunction

  // Reference model: collect accepted bytes, emit a record at BYTES or on in_last.
  always @(negedge clk) begin
    if (rst) begin
      m_bytes.delete();
    end else begin
      if (in_valid && in_ready) begin
        m_bytes.push_back(in_data);
        if (m_bytes.size() == BYTES || in_last) begin
          exp_data_q.push_back(build_rec());
          exp_len_q.push_back(m_bytes.size());
          m_bytes.delete();
        end
      end
      if (out_valid && out_ready) begin
        got_data_q.push_back(out_data);
        got_len_q.push_back(int'(out_len));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic flush_queues();
    exp_data_q.delete(); exp_len_q.delete();
    got_data_q.delete(); got_len_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1; in_data = d; in_last = l;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if (!ok) begin failures++; $display("FAIL send_timeout in_ready=%0b required=1", in_ready); end
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(posedge clk); #1;
      if (got_data_q.size() >= exp_data_q.size()) begin ok = 1'b1; break; end
    end
    repeat (4) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy_man = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== '0 || out_len !== '0) begin
        failures++;
        $display("FAIL reset_state out_valid=%0b in_ready=%0b out_len=%0d required 0/0/0 data=0", out_valid, in_ready, out_len);
      end
    end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release in_ready=%0b required=1", in_ready); end
    @(posedge clk); #1;
    flush_queues();
  endtask

  task automatic test_full_record();
    int c0; bit ok;
    rdy_man = 1'b1;
    c0 = cyc;
    for (int i = 0; i < BYTES; i++) send_byte(8'(i), 1'b0);
    checks++;
    if (cyc - c0 != BYTES) begin failures++; $display("FAIL full_throughput cycles=%0d required=%0d", cyc - c0, BYTES); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data[W-1 -: 64] !== 64'h0001020304050607 || out_data[7:0] !== 8'h2F || out_len !== LW'(48)) begin
      failures++;
      $display("FAIL full_record out_valid=%0b a=%h last=%h len=%0d required 1/0001020304050607/2f/48", out_valid, out_data[W-1 -: 64], out_data[7:0], out_len);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL full_pulse out_valid=%0b required=0", out_valid); end
    @(posedge clk); #1;
    wait_drain(ok);
    checks++;
    if (!ok || got_data_q.size() != exp_data_q.size()) begin failures++; $display("FAIL full_count got=%0d required=%0d", got_data_q.size(), exp_data_q.size()); end
    for (int i = 0; i < got_data_q.size() && i < exp_data_q.size(); i++) begin
      checks++;
      if (got_data_q[i] !== exp_data_q[i] || got_len_q[i] !== exp_len_q[i]) begin
        failures++; $display("FAIL full_sb%0d len=%0d required=%0d data=%h required=%h", i, got_len_q[i], exp_len_q[i], got_data_q[i], exp_data_q[i]);
      end
    end
    flush_queues();
  endtask

  task automatic test_early_terminate();
    logic [W-1:0] exp_c; bit ok;
    exp_c = {40'hA1A2A3A4A5, 344'h0};
    rdy_man = 1'b1;
    for (int i = 0; i < 5; i++) send_byte(8'hA1 + 8'(i), (i == 4) ? 1'b1 : 1'b0);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== exp_c || out_len !== LW'(5)) begin
      failures++; $display("FAIL early_record valid=%0b len=%0d required 1/5 data=%h required=%h", out_valid, out_len, out_data, exp_c);
    end
    @(posedge clk); #1;
    for (int i = 0; i < BYTES; i++) send_byte(8'($urandom), 1'b0);
    wait_drain(ok);
    checks++;
    if (!ok || got_data_q.size() != 2 || exp_data_q.size() != 2) begin failures++; $display("FAIL early_count got=%0d required=2", got_data_q.size()); end
    for (int i = 0; i < got_data_q.size() && i < exp_data_q.size(); i++) begin
      checks++;
      if (got_data_q[i] !== exp_data_q[i] || got_len_q[i] !== exp_len_q[i]) begin
        failures++; $display("FAIL early_sb%0d len=%0d required=%0d data=%h required=%h", i, got_len_q[i], exp_len_q[i], got_data_q[i], exp_data_q[i]);
      end
    end
    flush_queues();
  endtask

  task automatic test_backpressure();
    bit ok;
    rdy_man = 1'b0;
    for (int i = 0; i < 2 * BYTES; i++) send_byte(8'($urandom), 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || exp_data_q.size() != 2 || out_data !== exp_data_q[0] || out_len !== LW'(48)) begin
        failures++; $display("FAIL hold_stall%0d in_ready=%0b out_valid=%0b len=%0d required 0/1/48", k, in_ready, out_valid, out_len);
      end
      @(posedge clk); #1;
    end
    rdy_man = 1'b1;
    @(posedge clk); #1;
    rdy_man = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1 || exp_data_q.size() != 2 || out_data !== exp_data_q[1] || out_len !== LW'(48)) begin
      failures++; $display("FAIL hold_exit out_valid=%0b in_ready=%0b len=%0d required 1/1/48", out_valid, in_ready, out_len);
    end
    @(posedge clk); #1;
    rdy_man = 1'b1;
    wait_drain(ok);
    checks++;
    if (!ok || got_data_q.size() != exp_data_q.size()) begin failures++; $display("FAIL hold_count got=%0d required=%0d", got_data_q.size(), exp_data_q.size()); end
    for (int i = 0; i < got_data_q.size() && i < exp_data_q.size(); i++) begin
      checks++;
      if (got_data_q[i] !== exp_data_q[i] || got_len_q[i] !== exp_len_q[i]) begin
        failures++; $display("FAIL hold_sb%0d len=%0d required=%0d data=%h required=%h", i, got_len_q[i], exp_len_q[i], got_data_q[i], exp_data_q[i]);
      end
    end
    flush_queues();
  endtask

  task automatic test_reset_mid();
    bit ok;
    rdy_man = 1'b1;
    for (int i = 0; i < 20; i++) send_byte(8'($urandom), 1'b0);
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
        failures++; $display("FAIL rstmid_state%0d out_valid=%0b in_ready=%0b required 0/0", k, out_valid, in_ready);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    flush_queues();
    for (int i = 0; i < BYTES; i++) send_byte(8'h30 + 8'(i), 1'b0);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data[W-1 -: 8] !== 8'h30 || out_len !== LW'(48)) begin
      failures++; $display("FAIL rstmid_record valid=%0b top=%h len=%0d required 1/30/48", out_valid, out_data[W-1 -: 8], out_len);
    end
    @(posedge clk); #1;
    wait_drain(ok);
    checks++;
    if (!ok || got_data_q.size() != 1 || exp_data_q.size() != 1) begin failures++; $display("FAIL rstmid_count got=%0d required=1", got_data_q.size()); end
    for (int i = 0; i < got_data_q.size() && i < exp_data_q.size(); i++) begin
      checks++;
      if (got_data_q[i] !== exp_data_q[i] || got_len_q[i] !== exp_len_q[i]) begin
        failures++; $display("FAIL rstmid_sb%0d len=%0d required=%0d data=%h required=%h", i, got_len_q[i], exp_len_q[i], got_data_q[i], exp_data_q[i]);
      end
    end
    flush_queues();
  endtask

  task automatic test_last_toggle();
    bit ok;
    rdy_man = 1'b1;
    rdy_mode = 1;
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < BYTES; i++) send_byte(8'($urandom), (i == BYTES - 1) ? 1'b1 : 1'b0);
    wait_drain(ok);
    rdy_mode = 0;
    @(posedge clk); #1;
    checks++;
    if (!ok || got_data_q.size() != 4 || exp_data_q.size() != 4) begin failures++; $display("FAIL toggle_count got=%0d required=4", got_data_q.size()); end
    for (int i = 0; i < got_data_q.size() && i < exp_data_q.size(); i++) begin
      checks++;
      if (got_data_q[i] !== exp_data_q[i] || got_len_q[i] !== 48) begin
        failures++; $display("FAIL toggle_sb%0d len=%0d required=48 data=%h required=%h", i, got_len_q[i], got_data_q[i], exp_data_q[i]);
      end
    end
    flush_queues();
  endtask

  task automatic test_last_invalid();
    bit ok;
    rdy_man = 1'b1;
    for (int i = 0; i < 20; i++) send_byte(8'($urandom), 1'b0);
    in_valid = 1'b0; in_last = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL lastinv_idle%0d out_valid=%0b required=0", k, out_valid); end
    end
    @(posedge clk); #1;
    in_last = 1'b0;
    for (int i = 20; i < BYTES; i++) send_byte(8'($urandom), 1'b0);
    wait_drain(ok);
    checks++;
    if (!ok || got_data_q.size() != 1 || exp_data_q.size() != 1) begin failures++; $display("FAIL lastinv_count got=%0d required=1", got_data_q.size()); end
    for (int i = 0; i < got_data_q.size() && i < exp_data_q.size(); i++) begin
      checks++;
      if (got_data_q[i] !== exp_data_q[i] || got_len_q[i] !== 48) begin
        failures++; $display("FAIL lastinv_sb%0d len=%0d required=48 data=%h required=%h", i, got_len_q[i], got_data_q[i], exp_data_q[i]);
      end
    end
    flush_queues();
  endtask

  task automatic test_random();
    bit ok; int len;
    rdy_man = 1'b1;
    rdy_mode = 2;
    for (int r = 0; r < 8; r++) begin
      len = $urandom_range(1, BYTES);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        send_byte(8'($urandom), (i == len - 1) ? ((len == BYTES) ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0);
      end
    end
    wait_drain(ok);
    rdy_mode = 0;
    @(posedge clk); #1;
    checks++;
    if (!ok || got_data_q.size() != 8 || exp_data_q.size() != 8) begin failures++; $display("FAIL random_count got=%0d required=8", got_data_q.size()); end
    for (int i = 0; i < got_data_q.size() && i < exp_data_q.size(); i++) begin
      checks++;
      if (got_data_q[i] !== exp_data_q[i] || got_len_q[i] !== exp_len_q[i]) begin
        failures++; $display("FAIL random_sb%0d len=%0d required=%0d data=%h required=%h", i, got_len_q[i], exp_len_q[i], got_data_q[i], exp_data_q[i]);
      end
    end
    flush_queues();
  endtask

  initial begin
    test_reset();
    test_full_record();
    test_early_terminate();
    test_backpressure();
    test_reset_mid();
    test_last_toggle();
    test_last_invalid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
